// File: rtl/ifu_pkg.sv
// Shared encodings and defaults for the instruction fetch unit.
package ifu_pkg;

  // Next-PC select encodings driven by the controller.
  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  // Base of instruction space and PC value after reset.
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // Fetch unit control state: running, or halted after a fetch fault.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target computation and legality check.
module npc_calc
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IM_DEPTH = 4096
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_take,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] target,
  output logic        legal
);

  // Bounds are held in 33 bits so the end of instruction space cannot wrap.
  localparam logic [32:0] LOWER = {1'b0, PC_RESET};
  localparam logic [32:0] UPPER = {1'b0, PC_RESET} + (33'(IM_DEPTH) << 2);

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [32:0] target_wide;

  assign seq_pc = pc + 32'd4;
  // Word offset sign-extended and scaled to bytes.
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Select the candidate target for the requested next-PC kind.
  always_comb begin
    target = seq_pc;
    unique case (npc_op)
      NPC_SEQ: target = seq_pc;
      NPC_BR:  target = br_take ? (seq_pc + br_off) : seq_pc;
      NPC_J:   target = {pc[31:28], imm26, 2'b00};
      NPC_JR:  target = ra;
      default: target = seq_pc;
    endcase
  end

  assign target_wide = {1'b0, target};

  // A target is fetchable only if word aligned and inside the ROM window.
  assign legal = (target[1:0] == 2'b00) &&
                 (target_wide >= LOWER) &&
                 (target_wide < UPPER);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, stall, sticky fault halt, fetch counter.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  npc_op,
  input  logic        br_take,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_next;
  logic [31:0]  cnt_next;
  logic         fault_next;
  logic [31:0]  target;
  logic         legal;

  npc_calc #(
    .PC_RESET (PC_RESET),
    .IM_DEPTH (IM_DEPTH)
  ) u_npc_calc (
    .pc      (pc),
    .npc_op  (npc_op),
    .br_take (br_take),
    .imm16   (imm16),
    .imm26   (imm26),
    .ra      (ra),
    .target  (target),
    .legal   (legal)
  );

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      pc        <= PC_RESET;
      fetch_cnt <= 32'd0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      fetch_cnt <= cnt_next;
      fault     <= fault_next;
    end
  end

  // Next-state logic: advance on a legal target, halt on an illegal one, hold otherwise.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = fetch_cnt;
    fault_next = fault;
    if (state == RUN && en) begin
      if (legal) begin
        pc_next  = target;
        cnt_next = fetch_cnt + 32'd1;
      end else begin
        fault_next = 1'b1;
        state_next = HALT;
      end
    end
  end

  assign im_addr  = pc;
  assign pc_plus4 = pc + 32'd4;
  // A halted unit feeds nops to decode.
  assign instr    = (state == HALT) ? 32'h0 : im_data;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed plan followed by random traffic.
module tb_ifu_fetch;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int          IM_DEPTH = 4096;
  localparam longint      WIN_LO   = 64'h3000;
  localparam longint      WIN_HI   = 64'h3000 + 4 * IM_DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  npc_op;
  logic        br_take;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] ra;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        fault;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_halt;

  always #5 clk = ~clk;

  ifu_fetch #(
    .PC_RESET (PC_RESET),
    .IM_DEPTH (IM_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .npc_op    (npc_op),
    .br_take   (br_take),
    .imm16     (imm16),
    .imm26     (imm26),
    .ra        (ra),
    .im_addr   (im_addr),
    .im_data   (im_data),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .instr     (instr),
    .fault     (fault),
    .fetch_cnt (fetch_cnt)
  );

  // Bench ROM contents: a distinct word per address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign im_data = rom_word(im_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("im_addr", im_addr, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("instr", instr, m_halt ? 32'h0 : rom_word(m_pc));
    check("fault", {31'b0, fault}, {31'b0, m_halt});
    check("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic model_reset();
    m_pc   = PC_RESET;
    m_cnt  = 0;
    m_halt = 0;
  endtask

  // One clock edge with the given request; model follows the spec rules directly.
  task automatic tick(input bit e, input logic [1:0] op, input bit tk,
                      input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] r);
    logic [31:0] tgt;
    longint      lt;
    en = e; npc_op = op; br_take = tk; imm16 = i16; imm26 = i26; ra = r;
    @(posedge clk);
    case (op)
      2'd0: tgt = m_pc + 32'd4;
      2'd1: tgt = tk ? (m_pc + 32'd4 + 32'(int'($signed(i16)) * 4)) : (m_pc + 32'd4);
      2'd2: tgt = (m_pc & 32'hF000_0000) | (32'(i26) * 4);
      default: tgt = r;
    endcase
    lt = longint'({32'b0, tgt});
    if (!m_halt && e) begin
      if ((tgt % 4 == 0) && lt >= WIN_LO && lt < WIN_HI) begin
        m_pc  = tgt;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_halt = 1;
      end
    end
    #1;
    check_all();
    n_txn++;
    $display("txn %0d en=%0b op=%0d tgt=%h pc=%h cnt=%0d halt=%0b",
             n_txn, e, op, tgt, pc, fetch_cnt, fault);
  endtask

  // Reset pulse placed between clock edges; effect must be visible before the next edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; npc_op = 2'd0; br_take = 1'b0;
    imm16 = '0; imm26 = '0; ra = '0;
    model_reset();
    #12;
    check_all();
    check("reset_pc", pc, 32'h3000);
    reset = 1'b0;

    // Sequential fetch.
    tick(1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    tick(1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    tick(1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("plan_seq_pc", pc, 32'h300C);
    check("plan_seq_cnt", fetch_cnt, 32'd3);

    // Branches taken and not taken.
    tick(1, 2'd3, 0, 16'h0, 26'h0, 32'h3008);
    tick(1, 2'd1, 1, 16'hFFFE, 26'h0, 32'h0);
    check("plan_br_taken", pc, 32'h3004);
    tick(1, 2'd3, 0, 16'h0, 26'h0, 32'h3008);
    tick(1, 2'd1, 0, 16'hFFFE, 26'h0, 32'h0);
    check("plan_br_not", pc, 32'h300C);

    // Jump and register jump.
    tick(1, 2'd3, 0, 16'h0, 26'h0, 32'h3000);
    tick(1, 2'd2, 0, 16'h0, 26'h0000C10, 32'h0);
    check("plan_j", pc, 32'h3040);
    tick(1, 2'd3, 0, 16'h0, 26'h0, 32'h3100);
    check("plan_jr", pc, 32'h3100);

    // Misaligned JR halts; further edges change nothing.
    tick(1, 2'd3, 0, 16'h0, 26'h0, 32'h3102);
    check("plan_fault", {31'b0, fault}, 32'd1);
    check("plan_fault_instr", instr, 32'h0);
    for (int i = 0; i < 5; i++) tick(1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("plan_halt_pc", pc, 32'h3100);

    // Stalled illegal target raises no fault until en rises.
    async_reset();
    for (int i = 0; i < 4; i++) tick(0, 2'd3, 0, 16'h0, 26'h0, 32'h0);
    check("plan_stall_fault", {31'b0, fault}, 32'd0);
    tick(1, 2'd3, 0, 16'h0, 26'h0, 32'h0);
    check("plan_en_fault", {31'b0, fault}, 32'd1);

    // Reset from HALT, then step off the last legal word.
    async_reset();
    check("plan_rst_cnt", fetch_cnt, 32'd0);
    tick(1, 2'd3, 0, 16'h0, 26'h0, 32'h6FFC);
    tick(1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("plan_last_word", pc, 32'h6FFC);
    check("plan_last_fault", {31'b0, fault}, 32'd1);
    async_reset();

    // Random traffic, mostly in-window targets with occasional excursions.
    for (int i = 0; i < 600; i++) begin
      bit          e;
      logic [1:0]  op;
      logic [15:0] i16;
      logic [25:0] i26;
      logic [31:0] r;
      e   = ($urandom_range(0, 9) < 8);
      op  = 2'($urandom_range(0, 3));
      i16 = ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 128)) - 64);
      i26 = ($urandom_range(0, 19) == 0) ? 26'($urandom) : 26'($urandom_range(32'hBF0, 32'h1C10));
      r   = ($urandom_range(0, 9) == 0) ? $urandom
                                         : (32'h3000 + (32'($urandom_range(0, 4095)) << 2));
      tick(e, op, 1'($urandom), i16, i26, r);
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit that drives the instruction memory. Holds the program counter, computes the next PC from sequential, branch, jump and register-jump requests, and presents the fetched word to decode. Sits between the controller/ALU and the instruction memory. The memory is a combinational word-addressed ROM based at 0x0000_3000. Adds stall support, a sticky fetch-fault halt and a fetch counter for debug.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset and base of instruction space
- IM_DEPTH, 4096, instruction memory size in 32-bit words

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- en  in  1  1 = PC may advance this cycle; 0 = stall, hold all state
- npc_op  in  2  next-PC select: SEQ, BR, J, JR (package encodings)
- br_take  in  1  branch condition from ALU; used only when npc_op = BR
- imm16  in  16  branch offset in words, signed
- imm26  in  26  jump target field
- ra  in  32  register jump target for JR
- im_addr  out  32  byte address to instruction memory, equals pc
- im_data  in  32  instruction word returned combinationally by memory
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, used as the link value
- instr  out  32  instruction to decode
- fault  out  1  sticky fetch fault, unit halted
- fetch_cnt  out  32  number of PC advances since reset

## Operation
- States: RUN, HALT. Reset enters RUN.
- Target computation, all 32-bit with wrap on overflow:
  - SEQ → pc+4.
  - BR → br_take ? pc+4 + (sign_ext(imm16) << 2) : pc+4.
  - J → {pc[31:28], imm26, 2'b00}.
  - JR → ra.
- Legal target: target[1:0] == 0, PC_RESET ≤ target, and target < PC_RESET + 4*IM_DEPTH. Compare unsigned in 33 bits so the upper bound does not wrap.
- RUN with en = 1 and a legal target:
  - pc ← target.
  - fetch_cnt ← fetch_cnt + 1, wrapping at 2^32.
- RUN with en = 1 and an illegal target:
  - pc holds.
  - fault ← 1, state ← HALT.
  - fetch_cnt does not increment.
- RUN with en = 0: nothing changes; no fault check is made.
- HALT: pc, fetch_cnt and fault hold regardless of en and npc_op. Only reset exits HALT.
- instr = (state == HALT) ? 32'h0 : im_data. The 0 word is a nop.
- im_addr = pc. pc_plus4 = pc + 4. Both are always valid, including in HALT.

## Timing
- Reset values: pc = PC_RESET, im_addr = PC_RESET, pc_plus4 = PC_RESET+4, fault = 0, fetch_cnt = 0, state RUN.
- instr is instr = im_data combinationally from pc (same cycle), subject only to the HALT gate.
- Next-PC decision takes effect at the next rising edge after inputs settle: one cycle per instruction, no bubbles.
- Fault is visible the cycle after the offending edge. The instr gate to 0 applies from that same cycle.
- Reset asserted in any state takes effect without waiting for clk. On the first edge after reset deasserts, the normal RUN rules apply.
- en = 0 together with an illegal target: no fault. The target is evaluated only on an advancing edge.
- Last legal word, PC_RESET + 4*(IM_DEPTH-1), with SEQ → fault.

## Structure
- Shared package ifu_pkg holds:
  - the NPC_SEQ = 2'd0, NPC_BR = 2'd1, NPC_J = 2'd2, NPC_JR = 2'd3 encodings;
  - the state encoding (RUN = 1'b0, HALT = 1'b1);
  - the PC_RESET default.
- One natural sub-module: npc_calc. It is combinational and produces the target and the legal flag from pc, npc_op, br_take, imm16, imm26, ra.
- The top holds the pc, state, fault and fetch_cnt registers.

## Test plan
- Reset then 3 edges SEQ, en = 1 → pc 3000, 3004, 3008, 300C; fetch_cnt = 3; instr tracks im_data.
- pc = 3008, BR, br_take = 1, imm16 = 16'hFFFE → pc = 3004. Same with br_take = 0 → pc = 300C.
- pc = 3000, J, imm26 = 26'h0000C10 → pc = 3040. Then JR, ra = 32'h0000_3100 → pc = 3100.
- JR, ra = 32'h0000_3102 (misaligned) → fault = 1, pc holds, instr = 0. Then 5 more edges with SEQ → nothing changes.
- en = 0 for 4 edges with JR, ra = 0 → pc, fetch_cnt and fault unchanged. Raising en → fault = 1.
- From HALT, pulse reset between clock edges → pc = 3000 and fault = 0 immediately, fetch_cnt = 0. pc = 6FFC with SEQ → fault.
